// File: rtl/wb_uart_tx.sv
// Wishbone console UART transmitter: TX FIFO, 8N1 serializer, status and irq.
// Optional console echo of each transmitted byte: define WB_UART_TX_SIM_PRINT_EN.
module wb_uart_tx #(
  parameter logic [29:0] BASE_ADR        = 30'h04400300,
  parameter int          FIFO_DEPTH_LOG2 = 4,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd868
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [29:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        uart_tx,
  output logic        irq
);
  localparam int L     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << L;

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;

  logic         r_ack;
  logic [31:0]  r_dat;
  logic         r_tx;
  logic         r_irq;
  logic [15:0]  r_div;
  logic         r_ctrl;
  logic         r_ovf;
  logic [7:0]   r_mem [DEPTH];
  logic [L-1:0] r_wptr;
  logic [L-1:0] r_rptr;
  logic [L:0]   r_level;
  state_t       r_state;
  logic [7:0]   r_shift;
  logic [15:0]  r_dlat;
  logic [15:0]  r_cnt;
  logic [2:0]   r_bit;

  logic        w_hit, w_req, w_wr;
  logic [1:0]  w_off;
  logic        w_full, w_empty, w_busy;
  logic        w_push_req, w_push, w_pop;
  logic [15:0] w_div_eff;
  logic        w_last;
  logic [31:0] w_stat;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_hit  = wb_adr_i[29:2] == BASE_ADR[29:2];
  assign w_req  = wb_cyc_i & wb_stb_i & ~r_ack & w_hit;
  assign w_wr   = w_req & wb_we_i;
  assign w_off  = wb_adr_i[1:0];

  assign w_full     = r_level == (L+1)'(DEPTH);
  assign w_empty    = r_level == '0;
  assign w_busy     = r_state != S_IDLE;
  assign w_push_req = w_wr & (w_off == 2'd0) & wb_sel_i[0];
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_last     = r_cnt == (r_dlat - 16'd1);

  assign w_stat = {{(23-L){1'b0}}, r_level, 4'b0000,
                   r_ovf, w_busy, w_empty, w_full};
  assign w_unused = ^{wb_sel_i[3:2], wb_dat_i[31:16]};

  always_comb begin
    w_rdata = '0;
    unique case (w_off)
      2'd0: w_rdata = '0;
      2'd1: w_rdata = {16'h0000, r_div};
      2'd2: w_rdata = w_stat;
      2'd3: w_rdata = {31'h0, r_ctrl};
    endcase
  end

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = 1'b0;
  assign uart_tx  = r_tx;
  assign irq      = r_irq;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_div  <= DEFAULT_DIVISOR;
      r_ctrl <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_req ? w_rdata : 32'h0;
      if (w_push_req && w_full)
        r_ovf <= 1'b1;
      if (w_wr) begin
        if (w_off == 2'd1 && wb_sel_i[0]) r_div[7:0]  <= wb_dat_i[7:0];
        if (w_off == 2'd1 && wb_sel_i[1]) r_div[15:8] <= wb_dat_i[15:8];
        if (w_off == 2'd2 && wb_sel_i[0] && wb_dat_i[3]) r_ovf <= 1'b0;
        if (w_off == 2'd3 && wb_sel_i[0]) r_ctrl <= wb_dat_i[0];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wptr] <= wb_dat_i[7:0];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // Divisor is latched per frame so mid-frame DIVISOR writes wait for the next byte.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_shift <= '0;
      r_dlat  <= 16'd1;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_dlat  <= w_div_eff;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_irq <= 1'b0;
    else         r_irq <= r_ctrl & w_empty & ~w_busy;
  end

`ifdef WB_UART_TX_SIM_PRINT_EN
  always @(posedge sys_clk) begin
    if (!sys_rst && w_pop) $write("%c", r_mem[r_rptr]);
  end
`endif

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed testbench for wb_uart_tx: register access, framing, FIFO, irq, reset.
module tb_wb_uart_tx;
  localparam logic [29:0] A_RXTX = 30'h04400300;
  localparam logic [29:0] A_DIV  = 30'h04400301;
  localparam logic [29:0] A_STAT = 30'h04400302;
  localparam logic [29:0] A_CTRL = 30'h04400303;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [29:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        uart_tx;
  logic        irq;

  int n_chk  = 0;
  int n_fail = 0;

  wb_uart_tx dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_we_i (wb_we_i),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [29:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic we,
                     output bit acked, output logic [31:0] rd);
    @(negedge sys_clk);
    wb_adr_i = a; wb_dat_i = d; wb_sel_i = s; wb_we_i = we;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    acked = 1'b0; rd = '0;
    for (int i = 0; i < 6; i++) begin
      @(posedge sys_clk); #1;
      if (wb_ack_o) begin
        acked = 1'b1;
        rd = wb_dat_o;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    bit ak; logic [31:0] rd;
    bus(a, d, s, 1'b1, ak, rd);
    if (!ak) check("wr_ack_timeout", 32'(ak), 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [29:0] a,
                        input logic [31:0] exp);
    bit ak; logic [31:0] rd;
    bus(a, 32'h0, 4'hF, 1'b0, ak, rd);
    if (!ak) check("rd_ack_timeout", 32'(ak), 32'd1);
    check(tag, rd, exp);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Called right after an RXTX write returns; the first sample is one edge later.
  task automatic frame_chk(input string tag, input logic [7:0] b, input int d);
    logic [9:0] fr;
    int good;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      good = 0;
      for (int c = 0; c < d; c++) begin
        @(posedge sys_clk); #1;
        if (uart_tx === fr[i]) good++;
      end
      check($sformatf("%s_bit%0d", tag, i), 32'(good), 32'(d));
    end
  endtask

  initial begin
    bit ak;
    logic [31:0] rd;
    int lows;

    do_reset();
    @(posedge sys_clk); #1;
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_err", 32'(wb_err_o), 32'd0);
    rd_chk("rst_div", A_DIV, 32'h0000_0364);
    check("ack_one_cycle", 32'(wb_ack_o), 32'd1);
    @(posedge sys_clk); #1;
    check("ack_drop", 32'(wb_ack_o), 32'd0);
    check("dat_idle_zero", wb_dat_o, 32'd0);
    rd_chk("rst_stat", A_STAT, 32'h2);
    rd_chk("rst_ctrl", A_CTRL, 32'h0);
    rd_chk("rxtx_read", A_RXTX, 32'h0);

    bus(30'h04400304, 32'h41, 4'hF, 1'b1, ak, rd);
    check("nohit_ack", 32'(ak), 32'd0);
    bus(30'h04400305, 32'h5, 4'hF, 1'b1, ak, rd);
    check("nohit_ack2", 32'(ak), 32'd0);
    check("nohit_err", 32'(wb_err_o), 32'd0);
    rd_chk("nohit_stat", A_STAT, 32'h2);
    rd_chk("nohit_div", A_DIV, 32'h0000_0364);
    check("nohit_tx", 32'(uart_tx), 32'd1);

    wr(A_DIV, 32'h0000_00AB, 4'h1);
    rd_chk("div_lane0", A_DIV, 32'h0000_03AB);
    wr(A_DIV, 32'h0000_1234, 4'h2);
    rd_chk("div_lane1", A_DIV, 32'h0000_12AB);

    wr(A_DIV, 32'd4, 4'h3);
    wr(A_RXTX, 32'h55, 4'h1);
    frame_chk("f55", 8'h55, 4);
    @(posedge sys_clk); #1;
    check("f55_idle_tx", 32'(uart_tx), 32'd1);
    rd_chk("f55_stat_done", A_STAT, 32'h2);

    wr(A_RXTX, 32'hA5, 4'h1);
    repeat (2) @(posedge sys_clk);
    rd_chk("busy_stat", A_STAT, 32'h6);
    repeat (50) @(posedge sys_clk);
    rd_chk("busy_done", A_STAT, 32'h2);

    wr(A_DIV, 32'h0, 4'h3);
    rd_chk("div_zero", A_DIV, 32'h0);
    wr(A_RXTX, 32'h0F, 4'h1);
    frame_chk("f0f", 8'h0F, 1);

    wr(A_DIV, 32'd1, 4'h3);
    repeat (5) @(posedge sys_clk);
    for (int i = 0; i < 17; i++) wr(A_RXTX, 32'(i), 4'h1);
    bus(A_STAT, 32'h0, 4'hF, 1'b0, ak, rd);
    check("stream_ovf", 32'(rd[3]), 32'd0);
    repeat (230) @(posedge sys_clk);
    rd_chk("stream_drain", A_STAT, 32'h2);

    wr(A_DIV, 32'd1000, 4'h3);
    for (int i = 0; i < 17; i++) wr(A_RXTX, 32'(8'h30 + i), 4'h1);
    rd_chk("fill_full", A_STAT, 32'h1005);
    wr(A_RXTX, 32'h7E, 4'h1);
    rd_chk("fill_ovf", A_STAT, 32'h100D);
    wr(A_STAT, 32'h8, 4'h1);
    rd_chk("ovf_clear", A_STAT, 32'h1005);

    do_reset();
    rd_chk("flush_stat", A_STAT, 32'h2);
    wr(A_CTRL, 32'h1, 4'h1);
    rd_chk("ctrl_rd", A_CTRL, 32'h1);
    wr(A_DIV, 32'd2, 4'h3);
    repeat (2) @(posedge sys_clk); #1;
    check("irq_idle", 32'(irq), 32'd1);
    wr(A_RXTX, 32'h42, 4'h1);
    repeat (2) @(posedge sys_clk); #1;
    check("irq_start", 32'(irq), 32'd0);
    repeat (12) @(posedge sys_clk); #1;
    check("irq_mid", 32'(irq), 32'd0);
    repeat (10) @(posedge sys_clk); #1;
    check("irq_done", 32'(irq), 32'd1);
    wr(A_CTRL, 32'h0, 4'h1);
    repeat (2) @(posedge sys_clk); #1;
    check("irq_off", 32'(irq), 32'd0);

    wr(A_DIV, 32'd8, 4'h3);
    for (int i = 0; i < 4; i++) wr(A_RXTX, 32'h00, 4'h1);
    repeat (20) @(posedge sys_clk);
    @(negedge sys_clk);
    check("pre_rst_tx", 32'(uart_tx), 32'd0);
    #2 sys_rst = 1'b1;
    #1 check("async_rst_tx", 32'(uart_tx), 32'd1);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    rd_chk("post_rst_stat", A_STAT, 32'h2);
    rd_chk("post_rst_div", A_DIV, 32'h0000_0364);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge sys_clk); #1;
      if (uart_tx !== 1'b1) lows++;
    end
    check("post_rst_quiet", 32'(lows), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
